// File: rtl/bram_block_reader.sv
// Read-side master for the ThresholdCutter sample BRAM: streams one block of words out on valid/ready.
// Define BRAM_RD_REG_EN when the BRAM read data is registered (1-cycle latency); a 2-entry skid buffer is then used.
module bram_block_reader #(
    parameter int BLOCK_NUM_INDEX   = 6,
    parameter int BLOCK_DEPTH_INDEX = 9,
    parameter int BLOCK_WIDTH       = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic [BLOCK_NUM_INDEX-1:0]                   req_block,
    input  logic [BLOCK_DEPTH_INDEX:0]                   req_len,
    output logic [BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX-1:0] bram_raddr,
    input  logic [BLOCK_WIDTH-1:0]                       bram_data_i,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic [BLOCK_WIDTH-1:0]                       m_data,
    output logic                                         m_last,
    output logic                                         busy,
    output logic                                         done
);

    localparam int LW = BLOCK_DEPTH_INDEX + 1;
    localparam logic [LW-1:0] FULL_LEN = {1'b1, {BLOCK_DEPTH_INDEX{1'b0}}};

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                       r_state;
    logic [BLOCK_NUM_INDEX-1:0]   r_blk;
    logic [LW-1:0]                r_len;
    logic [BLOCK_DEPTH_INDEX-1:0] r_wordCnt;
    logic [LW-1:0]                r_issuedCnt;
    logic                         r_done;
    logic [LW-1:0]                w_effLen;
    logic                         w_lastHs;

    // A zero length or anything beyond one block reads the whole block.
    assign w_effLen   = (req_len == '0 || req_len > FULL_LEN) ? FULL_LEN : req_len;
    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign bram_raddr = {r_blk, r_wordCnt};

`ifdef BRAM_RD_REG_EN
    logic [BLOCK_WIDTH-1:0] r_buf [2];
    logic                   r_head;
    logic [1:0]             r_cnt;
    logic                   r_inflight;
    logic [LW-1:0]          r_popCnt;
    logic                   w_pop;
    logic                   w_issue;
    logic                   w_tail;
    logic [2:0]             w_occNext;

    assign m_valid   = (r_cnt != 2'd0);
    assign m_data    = r_buf[r_head];
    assign m_last    = m_valid && (r_popCnt == r_len - 1'b1);
    assign w_pop     = m_valid && m_ready;
    assign w_occNext = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    // Only issue an address when its data is guaranteed a free buffer entry on arrival.
    assign w_issue   = (r_state == STREAM) && (r_issuedCnt < r_len) && (w_occNext < 3'd2);
    assign w_tail    = r_head ^ r_cnt[0];
    assign w_lastHs  = (r_state == STREAM) && w_pop && m_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_len       <= '0;
            r_wordCnt   <= '0;
            r_issuedCnt <= '0;
            r_done      <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_head      <= 1'b0;
            r_cnt       <= 2'd0;
            r_inflight  <= 1'b0;
            r_popCnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_inflight <= 1'b0;
                    if (req_valid) begin
                        r_blk       <= req_block;
                        r_len       <= w_effLen;
                        r_wordCnt   <= '0;
                        r_issuedCnt <= '0;
                        r_popCnt    <= '0;
                        r_state     <= STREAM;
                    end
                end
                STREAM: begin
                    r_inflight <= w_issue;
                    r_cnt      <= w_occNext[1:0];
                    if (w_issue) begin
                        r_wordCnt   <= r_wordCnt + 1'b1;
                        r_issuedCnt <= r_issuedCnt + 1'b1;
                    end
                    if (r_inflight) begin
                        r_buf[w_tail] <= bram_data_i;
                    end
                    if (w_pop) begin
                        r_head   <= ~r_head;
                        r_popCnt <= r_popCnt + 1'b1;
                    end
                    if (w_lastHs) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    logic                   r_mValid;
    logic [BLOCK_WIDTH-1:0] r_mData;
    logic                   r_mLast;
    logic                   w_slot;
    logic                   w_load;

    assign m_valid  = r_mValid;
    assign m_data   = r_mData;
    assign m_last   = r_mLast;
    assign w_slot   = !r_mValid || m_ready;
    assign w_load   = (r_state == STREAM) && w_slot && (r_issuedCnt < r_len);
    assign w_lastHs = (r_state == STREAM) && r_mValid && m_ready && r_mLast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_len       <= '0;
            r_wordCnt   <= '0;
            r_issuedCnt <= '0;
            r_done      <= 1'b0;
            r_mValid    <= 1'b0;
            r_mData     <= '0;
            r_mLast     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_blk       <= req_block;
                        r_len       <= w_effLen;
                        r_wordCnt   <= '0;
                        r_issuedCnt <= '0;
                        r_state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_load) begin
                        r_mData     <= bram_data_i;
                        r_mValid    <= 1'b1;
                        r_mLast     <= (r_issuedCnt == r_len - 1'b1);
                        r_wordCnt   <= r_wordCnt + 1'b1;
                        r_issuedCnt <= r_issuedCnt + 1'b1;
                    end else if (w_slot) begin
                        r_mValid <= 1'b0;
                    end
                    if (w_lastHs) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bram_block_reader.sv
// Self-checking bench for bram_block_reader: BRAM model, beat monitor and a queue-based reference of expected words.
// Honours BRAM_RD_REG_EN by switching the BRAM model to a registered read and expecting one extra cycle of latency.
module tb_bram_block_reader;

    localparam int NBI   = 6;
    localparam int DBI   = 9;
    localparam int W     = 32;
    localparam int DEPTH = 512;
`ifdef BRAM_RD_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [NBI-1:0]   req_block;
    logic [DBI:0]     req_len;
    logic [NBI+DBI-1:0] bram_raddr;
    logic [W-1:0]     bram_data_i;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             m_last;
    logic             busy;
    logic             done;

    logic [W-1:0] mem [0:(1<<(NBI+DBI))-1];

    int checks = 0;
    int errors = 0;

    bram_block_reader #(.BLOCK_NUM_INDEX(NBI), .BLOCK_DEPTH_INDEX(DBI), .BLOCK_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block), .req_len(req_len),
        .bram_raddr(bram_raddr), .bram_data_i(bram_data_i),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef BRAM_RD_REG_EN
    always @(posedge clk) bram_data_i <= mem[bram_raddr];
`else
    assign bram_data_i = mem[bram_raddr];
`endif

    // Edge counter: at a negedge it holds the number of posedges seen so far.
    int cyc = 0;
    bit rstAtEdge = 1'b1;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rstAtEdge <= !rst_n;
    end

    // Monitor: logs beats, request handshakes and done pulses with the edge they belong to.
    logic [W-1:0] beatData[$];
    bit           beatLast[$];
    int           beatEdge[$];
    int           reqEdge[$];
    int           doneEdge[$];
    int           firstValidEdge = -1;
    int           holdErr = 0;
    bit           prevStall = 1'b0;
    logic [W-1:0] prevData;
    logic         prevLast;
    bit           readyPat[$];

    always @(negedge clk) begin
        if (prevStall && !rstAtEdge && (m_valid !== 1'b1 || m_data !== prevData || m_last !== prevLast))
            holdErr++;
        prevStall = (m_valid === 1'b1) && (m_ready === 1'b0) && (rst_n === 1'b1);
        prevData  = m_data;
        prevLast  = m_last;
        if (rst_n === 1'b1) begin
            if (m_valid === 1'b1 && firstValidEdge < 0) firstValidEdge = cyc;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                beatData.push_back(m_data);
                beatLast.push_back(m_last);
                beatEdge.push_back(cyc + 1);
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) reqEdge.push_back(cyc + 1);
            if (done === 1'b1) doneEdge.push_back(cyc);
        end
    end

    function automatic int effLen(input int len);
        return (len == 0 || len > DEPTH) ? DEPTH : len;
    endfunction

    function automatic logic [W-1:0] expWord(input int blk, input int idx);
        return mem[blk * DEPTH + idx];
    endfunction

    task automatic clearLog();
        beatData.delete();
        beatLast.delete();
        beatEdge.delete();
        reqEdge.delete();
        doneEdge.delete();
        firstValidEdge = -1;
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_block = '0;
        req_len   = '0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns the edge number of the request handshake, or -1 if it never happened.
    task automatic issueRequest(input int blk, input int len, output int hs);
        hs = -1;
        @(posedge clk);
        #1;
        req_block = NBI'(blk);
        req_len   = (DBI+1)'(len);
        req_valid = 1'b1;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                hs = cyc;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: readyPat then ready.
    task automatic runStream(input int nBeats, input int mode, output bit timedOut);
        timedOut = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (beatData.size() >= nBeats) begin
                timedOut = 1'b0;
                break;
            end
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (readyPat.size() > 0) ? readyPat.pop_front() : 1'b1;
            endcase
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        checks++; if (bram_raddr !== '0) begin errors++; $display("FAIL reset_raddr: got %h expected 0", bram_raddr); end
    endtask

    task automatic test_full_block();
        int hs;
        bit to;
        for (int i = 0; i < DEPTH; i++) mem[5 * DEPTH + i] = 32'h0500_0000 + i;
        clearLog();
        issueRequest(5, 0, hs);
        checks++; if (hs < 0) begin errors++; $display("FAIL full_req_accept: got timeout expected handshake"); end
        runStream(DEPTH, 0, to);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (to) begin errors++; $display("FAIL full_timeout: got %0d beats expected %0d", beatData.size(), DEPTH); end
        checks++; if (beatData.size() != DEPTH) begin errors++; $display("FAIL full_count: got %0d expected %0d", beatData.size(), DEPTH); end
        checks++; if (firstValidEdge != hs + LAT) begin errors++; $display("FAIL full_latency: got edge %0d expected %0d", firstValidEdge, hs + LAT); end
        for (int i = 0; i < beatData.size() && i < DEPTH; i++) begin
            checks++; if (beatData[i] !== 32'h0500_0000 + i) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, beatData[i], 32'h0500_0000 + i); end
            checks++; if (beatLast[i] !== (i == DEPTH - 1)) begin errors++; $display("FAIL full_last[%0d]: got %b expected %b", i, beatLast[i], i == DEPTH - 1); end
            checks++; if (beatEdge[i] != hs + LAT + 1 + i) begin errors++; $display("FAIL full_beat_edge[%0d]: got %0d expected %0d", i, beatEdge[i], hs + LAT + 1 + i); end
        end
        if (beatEdge.size() == DEPTH) begin
            checks++; if (doneEdge.size() != 1 || doneEdge[0] != beatEdge[DEPTH-1]) begin errors++; $display("FAIL full_done: got %0d pulses expected 1 after edge %0d", doneEdge.size(), beatEdge[DEPTH-1]); end
        end
    endtask

    task automatic test_backpressure();
        int hs;
        bit to;
        clearLog();
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        issueRequest(63, 3, hs);
        runStream(3, 2, to);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (to || beatData.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", beatData.size()); end
        checks++; if (firstValidEdge != hs + LAT) begin errors++; $display("FAIL bp_latency: got edge %0d expected %0d", firstValidEdge, hs + LAT); end
        for (int i = 0; i < beatData.size() && i < 3; i++) begin
            checks++; if (beatData[i] !== expWord(63, i)) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, beatData[i], expWord(63, i)); end
            checks++; if (beatLast[i] !== (i == 2)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", i, beatLast[i], i == 2); end
        end
        checks++; if (holdErr != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", holdErr); end
        checks++; if (doneEdge.size() != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", doneEdge.size()); end
    endtask

    task automatic test_random();
        int hs, blk, len, n;
        bit to;
        for (int t = 0; t < 5; t++) begin
            blk = $urandom_range(0, 63);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(1, 40);
            n   = effLen(len);
            clearLog();
            issueRequest(blk, len, hs);
            runStream(n, 1, to);
            repeat (3) @(posedge clk);
            #1;
            checks++; if (to || beatData.size() != n) begin errors++; $display("FAIL rand_count: blk %0d len %0d got %0d expected %0d", blk, len, beatData.size(), n); end
            for (int i = 0; i < beatData.size() && i < n; i++) begin
                checks++; if (beatData[i] !== expWord(blk, i) || beatLast[i] !== (i == n - 1)) begin
                    errors++; $display("FAIL rand_beat[%0d]: got %h/%b expected %h/%b", i, beatData[i], beatLast[i], expWord(blk, i), i == n - 1);
                end
            end
            checks++; if (doneEdge.size() != 1) begin errors++; $display("FAIL rand_done: got %0d pulses expected 1", doneEdge.size()); end
            checks++; if (holdErr != 0) begin errors++; $display("FAIL rand_hold: got %0d unstable stalls expected 0", holdErr); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] expQ[$];
        bit           expL[$];
        expQ = '{expWord(1, 0), expWord(1, 1), expWord(2, 0), expWord(2, 1)};
        expL = '{1'b0, 1'b1, 1'b0, 1'b1};
        clearLog();
        @(posedge clk);
        #1;
        m_ready   = 1'b1;
        req_block = NBI'(1);
        req_len   = (DBI+1)'(2);
        req_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (reqEdge.size() >= 1) req_block = NBI'(2);
            if (reqEdge.size() >= 2) req_valid = 1'b0;
            if (beatData.size() >= 4 && req_valid == 1'b0) break;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (reqEdge.size() != 2 || beatData.size() != 4) begin
            errors++; $display("FAIL b2b_counts: got %0d reqs %0d beats expected 2 reqs 4 beats", reqEdge.size(), beatData.size());
        end else begin
            checks++; if (reqEdge[1] != beatEdge[1] + 1) begin errors++; $display("FAIL b2b_accept_edge: got %0d expected %0d", reqEdge[1], beatEdge[1] + 1); end
            checks++; if (beatEdge[2] != reqEdge[1] + LAT + 1) begin errors++; $display("FAIL b2b_second_first_beat: got %0d expected %0d", beatEdge[2], reqEdge[1] + LAT + 1); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (beatData[i] !== expQ[i] || beatLast[i] !== expL[i]) begin
                    errors++; $display("FAIL b2b_beat[%0d]: got %h/%b expected %h/%b", i, beatData[i], beatLast[i], expQ[i], expL[i]);
                end
            end
            checks++; if (doneEdge.size() != 2 || doneEdge[0] != beatEdge[1]) begin errors++; $display("FAIL b2b_done: got %0d pulses expected 2", doneEdge.size()); end
        end
    endtask

    task automatic test_reset_midstream();
        int hs;
        bit to;
        clearLog();
        issueRequest(7, 64, hs);
        runStream(10, 0, to);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_m_valid: got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mrst_req_ready: got %b expected 1", req_ready); end
        checks++; if (m_last !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mrst_last_done: got %b/%b expected 0/0", m_last, done); end
        checks++; if (bram_raddr !== '0 || m_data !== '0) begin errors++; $display("FAIL mrst_addr_data: got %h/%h expected 0/0", bram_raddr, m_data); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (to || beatData.size() != 10) begin errors++; $display("FAIL mrst_partial_count: got %0d expected 10", beatData.size()); end
        for (int i = 0; i < beatData.size() && i < 10; i++) begin
            checks++; if (beatData[i] !== expWord(7, i)) begin errors++; $display("FAIL mrst_partial[%0d]: got %h expected %h", i, beatData[i], expWord(7, i)); end
        end
        clearLog();
        issueRequest(8, 16, hs);
        runStream(16, 1, to);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (to || beatData.size() != 16) begin errors++; $display("FAIL mrst_new_count: got %0d expected 16", beatData.size()); end
        for (int i = 0; i < beatData.size() && i < 16; i++) begin
            checks++; if (beatData[i] !== expWord(8, i) || beatLast[i] !== (i == 15)) begin
                errors++; $display("FAIL mrst_new[%0d]: got %h/%b expected %h/%b", i, beatData[i], beatLast[i], expWord(8, i), i == 15);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int hs;
        bit to;
        clearLog();
        issueRequest(10, 20, hs);
        m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_block = NBI'(9);
            req_len   = (DBI+1)'(5);
            req_valid = 1'b1;
            @(negedge clk);
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_req_ready: got %b expected 0", req_ready); end
            checks++; if (bram_raddr[NBI+DBI-1:DBI] !== NBI'(10)) begin errors++; $display("FAIL busy_raddr_block: got %0d expected 10", bram_raddr[NBI+DBI-1:DBI]); end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        runStream(20, 1, to);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (reqEdge.size() != 1) begin errors++; $display("FAIL busy_req_count: got %0d expected 1", reqEdge.size()); end
        checks++; if (to || beatData.size() != 20) begin errors++; $display("FAIL busy_count: got %0d expected 20", beatData.size()); end
        for (int i = 0; i < beatData.size() && i < 20; i++) begin
            checks++; if (beatData[i] !== expWord(10, i)) begin errors++; $display("FAIL busy_data[%0d]: got %h expected %h", i, beatData[i], expWord(10, i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << (NBI + DBI)); i++) mem[i] = $urandom;
        test_reset();
        test_full_block();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        test_ignore_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_block_reader.md
Name: bram_block_reader

Overview:
- Read-side master for the ThresholdCutter sample BRAM. The write side fills 64 blocks of 512 x 32-bit words.
- Accepts a request for one block plus a word count, then drives the BRAM read address.
- Streams the words out on a valid/ready interface, with the final word flagged.
- Sits between the BRAM and the downstream threshold/feature logic.

Parameters:
- BLOCK_NUM_INDEX, 6, log2 of the number of blocks (64).
- BLOCK_DEPTH_INDEX, 9, log2 of the words per block (512).
- BLOCK_WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  1  block read request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_block  input  BLOCK_NUM_INDEX  block index to read.
- req_len  input  BLOCK_DEPTH_INDEX+1  number of words to read; 0 means a full block (2^BLOCK_DEPTH_INDEX); values above the full block are clamped to the full block.
- bram_raddr  output  BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX  BRAM read address, formed as {block, word}.
- bram_data_i  input  BLOCK_WIDTH  BRAM read data.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream ready.
- m_data  output  BLOCK_WIDTH  output word.
- m_last  output  1  high with the final word of the request.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse in the cycle after the last-word handshake.

Behaviour:
- Reset (rst_n low at a posedge) is the same at any time, including mid-stream:
  - state -> IDLE; m_valid, m_last, busy, done -> 0; m_data -> 0; bram_raddr -> 0; internal counters -> 0.
  - Any in-flight request is discarded; no partial words appear after reset.
- FSM states: IDLE, STREAM.
- IDLE:
  - req_ready=1.
  - On handshake: latch req_block, latch the effective length L (1..512), clear word_cnt and issued_cnt, go to STREAM.
- STREAM:
  - req_ready=0; req_valid is ignored.
  - bram_raddr = {blk_reg, word_cnt}.
  - Load condition: (!m_valid || m_ready) && issued_cnt < L.
  - On load: m_data <= bram_data_i; m_valid <= 1; m_last <= (issued_cnt == L-1); word_cnt++, issued_cnt++.
  - When (!m_valid || m_ready) and issued_cnt == L: m_valid <= 0.
  - On the handshake of the m_last beat: go to IDLE; done pulses 1 the next cycle.
  - m_data and m_last hold stable while m_valid && !m_ready (AXI-style; valid is never withdrawn before the handshake).
- Latency: request handshake at edge N gives the first word valid after edge N+1.
- Throughput: 1 word per cycle while m_ready=1. A back-to-back request costs one idle bubble, because req_ready is high only in IDLE.
- Address width: word_cnt is BLOCK_DEPTH_INDEX bits and never wraps into the next block, because L <= 2^BLOCK_DEPTH_INDEX. For L=512, the last address is {blk,511}.
- Read data (default): BRAM read is combinational (data valid in the same cycle as the address).
- No arithmetic on the data; words pass through unchanged.

Optional Feature:
- Macro: BRAM_RD_REG_EN.
- Defined: the BRAM read is registered (1-cycle latency, as in the real BRAM IP).
  - The reader issues the address one cycle ahead and keeps a 2-entry skid buffer.
  - Throughput stays 1 word/cycle; first-word latency becomes edge N+2.
  - Backpressure never loses or duplicates a word; the issued-address count is at most the number of free buffer entries.
- Undefined: combinational read as described above; no skid buffer.

Test Plan:
- Full block, no backpressure: prefill block 5 with word[i]=0x0500_0000+i, request block=5, len=0, m_ready=1 -> 512 beats on consecutive cycles, data matches, m_last on beat 511 (0x050001FF), done one cycle later.
- Short read with backpressure: block 63, len=3, m_ready toggling 1,0,0,1,0,1 -> exactly 3 words in order; m_data held during stalls; m_last only on word 3.
- Back-to-back requests: req_valid held high with block 1 len 2, then block 2 len 2 -> second request accepted only after the first done, one bubble cycle, then block-2 data.
- Reset mid-stream: after 10 of 64 words of block 7, pull rst_n low for 1 cycle -> m_valid=0, busy=0, req_ready=1 next cycle; a new request for block 8 streams correctly from word 0.
- Request ignored while busy: pulse req_valid with block 9 during STREAM -> ignored; bram_raddr stays in the current block.
- With BRAM_RD_REG_EN defined: repeat the full-block and backpressure scenarios -> identical output data sequences; first word appears at edge N+2.
